// File: rtl/op_dispatcher.sv
// op_dispatcher: FIFO-buffered command queue feeding an operation unit over a
// start-level / ack-pulse handshake. Define OP_ACK_TIMEOUT_EN to add an ack watchdog.
module op_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [7:0]               req_data,
  output logic [1:0]               op_code,
  output logic [7:0]               op_data,
  output logic                     op_start,
  input  logic                     ack,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    mem_op   [DEPTH];
  logic [7:0]    mem_data [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, timeout_hit;

  // Readiness depends on the registered count only, so a full queue drops an
  // offer even when the head is popped on the same edge.
  assign req_ready = (count < CNT_FULL);
  assign push      = req_valid && req_ready;
  assign pending   = count;
  assign busy      = (state != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      IDLE, RELEASE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE:   if (ack || timeout_hit) state_nxt = RELEASE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      op_code  <= '0;
      op_data  <= '0;
      op_start <= 1'b0;
    end else begin
      state    <= state_nxt;
      op_start <= (state_nxt == ISSUE);
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        op_code <= mem_op[rd_ptr];
        op_data <= mem_data[rd_ptr];
      end
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  // NOTE: queue storage has no reset; emptiness is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_ptr]   <= req_op;
      mem_data[wr_ptr] <= req_data;
    end
  end

`ifdef OP_ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;

  // An ack arriving on the final allowed cycle takes priority over the timeout.
  assign timeout_hit = (state == ISSUE) && !ack && (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (pop)                 wait_cnt <= '0;
      else if (state == ISSUE) wait_cnt <= wait_cnt + TW'(1);
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule
